// File: rtl/weight_update_pkg.sv
// Shared types and width helpers for the weight flip/update path.
package weight_update_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT,
        WRITE,
        DONE
    } state_e;

    // Word address width for a BRAM of num_words entries (never below 1 bit).
    function automatic int calc_addr_w(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    // Counter width able to hold every value 0..w_size inclusive.
    function automatic int calc_cnt_w(input int w_size);
        return $clog2(w_size + 1);
    endfunction

endpackage

// File: rtl/popcount_word.sv
// Combinational population count of one BRAM word.
module popcount_word #(
    parameter  int WORD_W = 64,
    localparam int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic [WORD_W-1:0] word_i,
    output logic [CNT_W-1:0]  count_o
);

    // Sum the set bits of the word.
    always_comb begin
        // NOTE: blocking '=' is correct inside always_comb; each iteration must see the previous partial sum.
        count_o = '0;
        for (int i = 0; i < WORD_W; i++) begin
            count_o = count_o + CNT_W'(word_i[i]);
        end
    end

endmodule

// File: rtl/weight_flip_applier.sv
// Applies a flip mask to the weight BRAM by read-modify-write, skipping
// words whose mask slice is zero, and reports the number of flipped weights.
module weight_flip_applier
    import weight_update_pkg::*;
#(
    parameter  int W_SIZE       = 3072,
    parameter  int WORD_W       = 64,
    parameter  int BRAM_LATENCY = 2,
    localparam int NUM_WORDS    = W_SIZE / WORD_W,
    localparam int ADDR_W       = calc_addr_w(NUM_WORDS),
    localparam int CNT_W        = calc_cnt_w(W_SIZE)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flip_valid_in,
    output logic              flip_ready_out,
    input  logic [W_SIZE-1:0] flip_weight_in,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic              bram_we_out,
    output logic [WORD_W-1:0] bram_din_out,
    input  logic [WORD_W-1:0] bram_dout_in,
    output logic              done_out,
    output logic [CNT_W-1:0]  flips_applied_out
);

    localparam int POP_W  = $clog2(WORD_W + 1);
    // WAIT lasts BRAM_LATENCY-1 cycles; the counter is loaded with BRAM_LATENCY-2.
    localparam int WAIT_W = (BRAM_LATENCY > 2) ? $clog2(BRAM_LATENCY - 1) : 1;

    state_e              state_q;
    logic [W_SIZE-1:0]   mask_q;
    logic [ADDR_W-1:0]   word_idx_q;
    logic [CNT_W-1:0]    acc_q;
    logic [CNT_W-1:0]    flips_q;
    logic [WAIT_W-1:0]   wait_cnt_q;

    logic [WORD_W-1:0]   slice;
    logic [POP_W-1:0]    slice_pop;
    logic [CNT_W-1:0]    acc_d;
    logic                slice_zero;
    logic                last_word;

    // Select the mask slice belonging to the current word.
    always_comb begin
        // NOTE: default assignment first so no path leaves 'slice' unassigned (no latch).
        slice = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (word_idx_q == ADDR_W'(k)) begin
                slice = mask_q[k*WORD_W +: WORD_W];
            end
        end
    end

    popcount_word #(
        .WORD_W (WORD_W)
    ) u_popcount (
        .word_i  (slice),
        .count_o (slice_pop)
    );

    assign slice_zero = (slice == '0);
    assign last_word  = (word_idx_q == ADDR_W'(NUM_WORDS - 1));
    assign acc_d      = acc_q + CNT_W'(slice_pop);

    // Outputs decoded straight from registered state; the address is the word index register.
    assign flip_ready_out    = (state_q == IDLE);
    assign bram_addr_out     = word_idx_q;
    assign bram_we_out       = (state_q == WRITE);
    assign bram_din_out      = bram_dout_in ^ slice;
    assign done_out          = (state_q == DONE);
    assign flips_applied_out = flips_q;

    // Update FSM: walk every word, skip zero slices, read-wait-write nonzero ones.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking '<=' so all registers update from the same pre-edge values.
        if (rst_in) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            acc_q      <= '0;
            flips_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flip_valid_in) begin
                        // NOTE: mask_q is pure datapath, only meaningful after a handshake, so it carries no reset.
                        mask_q     <= flip_weight_in;
                        word_idx_q <= '0;
                        acc_q      <= '0;
                        state_q    <= CHECK;
                    end
                end
                CHECK: begin
                    if (slice_zero) begin
                        if (last_word) begin
                            state_q <= DONE;
                        end else begin
                            word_idx_q <= word_idx_q + 1'b1;
                        end
                    end else if (BRAM_LATENCY == 1) begin
                        state_q <= WRITE;
                    end else begin
                        wait_cnt_q <= WAIT_W'(BRAM_LATENCY - 2);
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= WRITE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                WRITE: begin
                    acc_q <= acc_d;
                    if (last_word) begin
                        state_q <= DONE;
                    end else begin
                        word_idx_q <= word_idx_q + 1'b1;
                        state_q    <= CHECK;
                    end
                end
                DONE: begin
                    flips_q <= acc_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
